// File: rtl/ack_monitor.sv
// Checks that ack rising edges arrive every EXP_PERIOD +/- TOL cycles, locks after LOCK_N good intervals.
// Optional ACK_MON_STICKY_ERR_EN: ERR is held until clear/rst instead of exiting on the next ack edge.
module ack_monitor #(
  parameter int EXP_PERIOD = 15,
  parameter int TOL        = 1,
  parameter int LOCK_N     = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ack,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] ack_count,
  output logic [7:0]       last_interval
);

  localparam int STK_W = $clog2(LOCK_N + 1);
  localparam logic [7:0]       LO_LIM   = 8'(EXP_PERIOD - TOL);
  localparam logic [7:0]       HI_LIM   = 8'(EXP_PERIOD + TOL);
  localparam logic [7:0]       TO_LIM   = 8'(EXP_PERIOD + TOL + 1);
  localparam logic [STK_W-1:0] LOCK_STK = STK_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, ERR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ack_s;
  logic             r_ack_p;
  logic [1:0]       r_smp_vld;
  logic [7:0]       r_ivl;
  logic [STK_W-1:0] r_streak;
  logic [STK_W-1:0] w_streak_nxt;
  logic [STK_W-1:0] w_streak_inc;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_last_nxt;
  logic             w_edge;
  logic             w_good;
  logic             w_timeout;

  // The previous sample must be a real post-reset sample, so an ack that is
  // already high when reset releases is not mistaken for a rising edge.
  assign w_edge       = r_ack_s & ~r_ack_p & r_smp_vld[1];
  assign w_good       = (r_ivl >= LO_LIM) && (r_ivl <= HI_LIM);
  assign w_timeout    = (r_ivl >= TO_LIM) && !w_edge;
  assign w_streak_inc = (r_streak >= LOCK_STK) ? r_streak : r_streak + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_s   <= 1'b0;
      r_ack_p   <= 1'b0;
      r_smp_vld <= 2'b00;
    end else begin
      r_ack_s   <= ack;
      r_ack_p   <= r_ack_s;
      r_smp_vld <= {r_smp_vld[0], 1'b1};
    end
  end

  // Interval counter: value at an edge is the number of clk edges since the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ivl <= 8'd0;
    end else if (clear) begin
      r_ivl <= 8'd0;
    end else if (w_edge) begin
      r_ivl <= 8'd1;
    end else if (r_ivl != 8'hFF) begin
      r_ivl <= r_ivl + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_count_nxt  = ack_count;
    w_last_nxt   = last_interval;
    if (clear) begin
      w_state_nxt  = IDLE;
      w_streak_nxt = '0;
      w_count_nxt  = '0;
      w_last_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            w_state_nxt  = TRACK;
            w_streak_nxt = '0;
          end
        end
        TRACK, LOCKED: begin
          if (w_edge) begin
            w_last_nxt = r_ivl;
            if (w_good) begin
              w_count_nxt  = (&ack_count) ? ack_count : ack_count + 1'b1;
              w_streak_nxt = w_streak_inc;
              if (w_streak_inc >= LOCK_STK) begin
                w_state_nxt = LOCKED;
              end
            end else begin
              w_state_nxt  = ERR;
              w_streak_nxt = '0;
            end
          end else if (w_timeout) begin
            w_state_nxt  = ERR;
            w_streak_nxt = '0;
          end
        end
        ERR: begin
`ifndef ACK_MON_STICKY_ERR_EN
          if (w_edge) begin
            w_state_nxt  = TRACK;
            w_streak_nxt = '0;
          end
`endif
        end
        default: begin
          w_state_nxt  = IDLE;
          w_streak_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_streak      <= '0;
      locked        <= 1'b0;
      err           <= 1'b0;
      ack_count     <= '0;
      last_interval <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_streak      <= w_streak_nxt;
      locked        <= (w_state_nxt == LOCKED);
      err           <= (w_state_nxt == ERR);
      ack_count     <= w_count_nxt;
      last_interval <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_ack_monitor.sv
// Directed bench for ack_monitor with default parameters; inputs driven and outputs sampled on negedge.
module tb_ack_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic        clear;
  logic        locked;
  logic        err;
  logic [15:0] ack_count;
  logic [7:0]  last_interval;

  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic err_seen = 1'b0;

  ack_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .ack           (ack),
    .clear         (clear),
    .locked        (locked),
    .err           (err),
    .ack_count     (ack_count),
    .last_interval (last_interval)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && err) err_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task pulse;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task do_clear;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    ack   = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(ack_count), 0);
    chk("rst_last", 32'(last_interval), 0);
    rst = 1'b0;
    wait_n(3);

    // 100 pulses every 15 cycles
    mon_en = 1'b1;
    repeat (4) begin pulse(); wait_n(14); end
    chk("a4_locked", 32'(locked), 0);
    chk("a4_count", 32'(ack_count), 3);
    chk("a4_last", 32'(last_interval), 15);
    pulse(); wait_n(1);
    chk("a5_locked", 32'(locked), 1);
    wait_n(13);
    repeat (95) begin pulse(); wait_n(14); end
    mon_en = 1'b0;
    chk("a_locked", 32'(locked), 1);
    chk("a_count", 32'(ack_count), 99);
    chk("a_last", 32'(last_interval), 15);
    chk("a_err_never", 32'(err_seen), 0);

    // ack stops: now 15 negedges past the last pulse
    wait_n(3);
    chk("to_err_early", 32'(err), 0);
    wait_n(1);
    chk("to_err", 32'(err), 1);
    chk("to_locked", 32'(locked), 0);
    chk("to_last", 32'(last_interval), 15);
    chk("to_count", 32'(ack_count), 99);

    do_clear();
    chk("clr_err", 32'(err), 0);
    chk("clr_count", 32'(ack_count), 0);
    chk("clr_last", 32'(last_interval), 0);

    // intervals 15,15,14,16,15
    wait_n(3);
    pulse(); wait_n(14);
    pulse(); wait_n(14);
    pulse(); wait_n(13);
    pulse(); wait_n(15);
    pulse(); wait_n(14);
    pulse(); wait_n(1);
    chk("b_count", 32'(ack_count), 5);
    chk("b_locked", 32'(locked), 1);
    chk("b_err", 32'(err), 0);
    chk("b_last", 32'(last_interval), 15);

    // interval of 12 while locked
    wait_n(10);
    pulse(); wait_n(1);
    chk("d_err", 32'(err), 1);
    chk("d_locked", 32'(locked), 0);
    chk("d_last", 32'(last_interval), 12);
    chk("d_count", 32'(ack_count), 5);
    wait_n(12);
    pulse(); wait_n(1);
`ifdef ACK_MON_STICKY_ERR_EN
    chk("d_sticky_err", 32'(err), 1);
    chk("d_sticky_count", 32'(ack_count), 5);
    wait_n(12);
    pulse(); wait_n(14);
    chk("d_sticky_err2", 32'(err), 1);
    do_clear();
    chk("d_sticky_clr", 32'(err), 0);
`else
    chk("d_exit_err", 32'(err), 0);
    chk("d_exit_locked", 32'(locked), 0);
    chk("d_exit_count", 32'(ack_count), 5);
    wait_n(12);
    repeat (3) begin pulse(); wait_n(14); end
    chk("d_3good_locked", 32'(locked), 0);
    pulse(); wait_n(1);
    chk("d_relock", 32'(locked), 1);
    chk("d_relock_count", 32'(ack_count), 9);
    do_clear();
`endif

    // clear coincident with an ack edge while locked
    wait_n(3);
    repeat (5) begin pulse(); wait_n(14); end
    chk("e_pre_locked", 32'(locked), 1);
    ack = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("e_locked", 32'(locked), 0);
    chk("e_err", 32'(err), 0);
    chk("e_count", 32'(ack_count), 0);
    chk("e_last", 32'(last_interval), 0);
    wait_n(3);
    pulse(); wait_n(14);
    pulse(); wait_n(1);
    chk("e_restart_count", 32'(ack_count), 1);

    // relock, then reset mid-interval with ack held high
    wait_n(13);
    repeat (3) begin pulse(); wait_n(14); end
    chk("f_locked", 32'(locked), 1);
    chk("f_count", 32'(ack_count), 4);
    pulse(); wait_n(6);
    rst = 1'b1;
    ack = 1'b1;
    #1;
    chk("f_rst_locked", 32'(locked), 0);
    chk("f_rst_err", 32'(err), 0);
    chk("f_rst_count", 32'(ack_count), 0);
    chk("f_rst_last", 32'(last_interval), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_n(40);
    chk("f_high_err", 32'(err), 0);
    chk("f_high_locked", 32'(locked), 0);
    chk("f_high_count", 32'(ack_count), 0);
    ack = 1'b0;
    wait_n(3);
    pulse(); wait_n(14);
    pulse(); wait_n(1);
    chk("f_after_count", 32'(ack_count), 1);
    chk("f_after_err", 32'(err), 0);
    chk("f_after_last", 32'(last_interval), 15);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ack_monitor.md
ACK_MONITOR -- requirements
Module: ack_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 15: the expected number of cycles between ack rising edges.
REQ-002 SHALL have parameter TOL, default 1: the allowed +/- deviation from EXP_PERIOD, in cycles.
REQ-003 SHALL have parameter LOCK_N, default 4: the number of consecutive in-tolerance intervals needed to lock.
REQ-004 SHALL have parameter CNT_W, default 16: the width of ack_count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port ack, input, 1 bit: the periodic acknowledge pulse from the upstream loop stage.
REQ-008 SHALL have port clear, input, 1 bit: synchronous restart of monitoring.
REQ-009 SHALL have port locked, output, 1 bit: high when the ack period has been stable for LOCK_N intervals.
REQ-010 SHALL have port err, output, 1 bit: high on a period violation or a missing ack.
REQ-011 SHALL have port ack_count, output, CNT_W bits: the number of in-tolerance acks.
REQ-012 SHALL have port last_interval, output, 8 bits: the most recent measured interval.

Function
REQ-013 SHALL register ack and detect a rising edge when the current sample is 1 and the previous sample is 0; a continuously high ack produces no further edges.
REQ-014 SHALL measure an interval as the number of clk edges between consecutive detected edges, saturating at 255; pulses every 15 cycles measure 15.
REQ-015 SHALL treat an interval as good if EXP_PERIOD-TOL <= interval <= EXP_PERIOD+TOL, and bad otherwise.
REQ-016 SHALL implement FSM states IDLE, TRACK, LOCKED and ERR.
REQ-017 SHALL, in IDLE, go to TRACK on the first edge; that edge starts the interval count, is not counted, and no timeout applies in IDLE.
REQ-018 SHALL, in TRACK or LOCKED, on a good edge: load last_interval, increment ack_count (saturating at all-ones) and increment the streak.
REQ-019 SHALL move TRACK to LOCKED when the streak reaches LOCK_N.
REQ-020 SHALL, in TRACK or LOCKED, on a bad edge: load last_interval, leave ack_count unchanged and go to ERR.
REQ-021 SHALL time out when EXP_PERIOD+TOL+1 cycles elapse since the last edge with no new edge (17 with defaults): go to ERR and leave last_interval unchanged.
REQ-022 SHALL register all outputs; each reflects a decision one cycle after the clk edge at which the ack edge or timeout is detected.
REQ-023 SHALL drive locked=1 only in LOCKED, and err=1 only in ERR.
REQ-024 SHALL make clear take priority over any simultaneous edge or timeout: go to IDLE, zero ack_count, last_interval and the streak, and deassert err and locked on the next cycle.
REQ-025 SHALL zero the streak on every entry to IDLE or ERR.

Reset
REQ-026 SHALL, on rst asserted, immediately set the state to IDLE and drive locked=0, err=0, ack_count=0 and last_interval=0, with the interval counter, streak and ack sample all cleared.
REQ-027 SHALL treat rst asserted mid-interval like power-up, and SHALL treat the first ack edge after rst deasserts as the IDLE start edge.

Configuration
REQ-028 SHALL, with ACK_MON_STICKY_ERR_EN defined, hold ERR until clear or rst, ignoring ack edges.
REQ-029 SHALL, without ACK_MON_STICKY_ERR_EN, exit ERR on the next ack edge to TRACK: that edge restarts the interval count, is not counted, and leaves err=0 one cycle later.

Verification
REQ-030 SHALL test this scenario: ack one-cycle pulses every 15 cycles, 100 pulses -> locked=1 after the 5th pulse (4 good intervals), err=0 throughout, ack_count=99, last_interval=15.
REQ-031 SHALL test this scenario: intervals 15,15,14,16,15 -> all good, ack_count=5, locked=1, err=0.
REQ-032 SHALL test this scenario: lock achieved, then ack stops -> err=1 exactly 17 cycles after the last edge plus 1 cycle of output latency, locked=0, last_interval=15.
REQ-033 SHALL test this scenario: lock achieved, then an interval of 12 -> err=1, last_interval=12, ack_count unchanged; without the macro the next edge gives err=0, locked=0, and 4 further good intervals re-lock; with the macro err stays 1 until clear.
REQ-034 SHALL test this scenario: clear asserted in the same cycle as an ack edge while locked -> the next cycle shows locked=0, err=0, ack_count=0, and the edge is not counted.
REQ-035 SHALL test this scenario: rst asserted for 1 cycle midway through an interval while locked -> outputs are zero immediately; ack held high after reset -> state stays IDLE with no timeout.
